ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle RV32M execute unit beside the ALU in EX, fed directly from the ID/EX pipeline register output. It computes MUL/MULH/MULHSU/MULHU with a shift-add datapath and DIV/DIVU/REM/REMU with a restoring divider. While it works, it raises `stall`, which deasserts `load` on the IF/ID and ID/EX registers and bubbles EX/MEM. Its result is muxed into the EX/MEM register in the cycle `done` is high.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  ID/EX output holds a valid M-extension instruction (opcode OP, funct7 0000001).
- flush  in  1  kill the instruction in EX; abandons any operation in progress.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  32  forwarded rs1 operand.
- rs2_data  in  32  forwarded rs2 operand.
- stall  out  1  hold IF/ID and ID/EX and insert a bubble into EX/MEM (combinational).
- done  out  1  single-cycle pulse; `result` is valid.
- result  out  32  registered result.

## Operation
- **State machine:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - `start & ~flush` latches funct3, operand magnitudes, sign flags and op class.
  - Divide special case (rs2 == 0, or DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): load `result` directly and go to DONE.
  - Otherwise clear the accumulator and the 5-bit counter and go to CALC.
- **CALC:** one iteration per cycle, 32 iterations (counter 0..31). Go to FIX after counter == 31.
  - Multiply: add the multiplicand to the upper half of the 64-bit product when the multiplier LSB is 1, then shift right.
  - Divide: shift remainder:quotient left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- **FIX:** apply the sign correction, load `result`, go to DONE.
  - Multiply: negate the 64-bit product if the operand signs differ. MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
  - Divide: negate the quotient if the signs differ. The remainder takes the dividend's sign.
- **Operand signedness:**
  - Signed: MULH both operands; MULHSU rs1 only; DIV/REM both operands.
  - Unsigned: all other ops. MUL is treated as unsigned; its low word is identical either way.
- **Special-case results:**
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- **DONE:** `done = 1`, `stall = 0`. Always go to IDLE. `start` is ignored here, because the same instruction is still presented while the pipeline advances.
- **stall:** `(IDLE & start & ~flush) | CALC | FIX`.
- **flush:**
  - In CALC or FIX: go to IDLE next cycle; `done` is not pulsed and `result` is unchanged.
  - In IDLE: suppresses the start.
  - In DONE: no effect (the instruction already retires).
- `result` holds its value until the next load.

## Timing
- **Reset (rst low, asynchronous):** state IDLE, counter 0, `result` = 0, `done` = 0. `stall` then follows `start`.
- **Normal op, `start` seen in IDLE at cycle T0:**
  - `stall` = 1 in T0..T33 (T1..T32 are CALC, T33 is FIX).
  - T34 is DONE: `done` = 1, `stall` = 0, `result` valid.
  - ID/EX loads the next instruction at the end of T34.
- **Special-case divide:** `stall` = 1 in T0 only; DONE in T1.
- **Back-to-back M ops:** the next `start` is accepted in the cycle after DONE. There is no dead cycle beyond the DONE cycle.
- **Reset mid-operation:** immediate IDLE; no `done`.
- **Simultaneous `flush` and the counter == 31 edge:** flush wins; go to IDLE.

## Test plan
- MUL rs1 = 7, rs2 = 0xFFFFFFFD -> `result` 0xFFFFFFEB, `done` at T34, `stall` high for exactly T0..T33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with `done` at T1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM same operands -> 0, each with `done` at T1.
- `flush` pulsed at T10 of a DIV -> IDLE at T11, no `done`, `result` keeps its prior value. A new `start` at T11 completes normally at T11 + 34.
- `rst` asserted at T5 of a MUL -> `done` = 0, `result` = 0 immediately. Two consecutive MULs with `start` held through DONE -> exactly two `done` pulses, 35 cycles apart.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if
// Bundles the EX-stage connection between the ID/EX pipeline register and
// the multi-cycle RV32M unit.
//   start    : ID/EX holds a valid M-extension instruction
//   flush    : kill the instruction in EX
//   funct3   : M-op select
//   rs1_data : forwarded rs1 operand
//   rs2_data : forwarded rs2 operand
//   stall    : hold IF/ID and ID/EX, bubble EX/MEM
//   done     : one-cycle pulse, result valid
//   result   : registered result
// master = pipeline side, slave = execute unit.
interface ex_muldiv_if;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        stall;
   logic        done;
   logic [31:0] result;

   modport master (
      output start, flush, funct3, rs1_data, rs2_data,
      input  stall, done, result
   );

   modport slave (
      input  start, flush, funct3, rs1_data, rs2_data,
      output stall, done, result
   );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv
// Multi-cycle RV32M execute unit. Multiplies with a 32-step shift-add
// datapath and divides with a 32-step restoring divider, both operating on
// operand magnitudes with a sign fix-up at the end. Divide-by-zero and signed
// overflow complete in a single cycle.
// Ports:
//   clk : pipeline clock
//   rst : asynchronous reset, active-low
//   bus : ex_muldiv_if.slave (start/flush/funct3/rs1_data/rs2_data in,
//         stall/done/result out)
module ex_muldiv (
   input  logic       clk,
   input  logic       rst,
   ex_muldiv_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Two's-complement negate when n is set.
   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic n);
      logic [31:0] r;
      if (n) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   logic [1:0]  state_r;
   logic [4:0]  cnt_r;
   logic [1:0]  sel_r;       // funct3[1:0] of the latched op
   logic        is_div_r;
   logic        neg_q_r;     // product / quotient needs negation
   logic        neg_r_r;     // remainder needs negation (dividend sign)
   logic [31:0] acc_r;       // product high word / partial remainder
   logic [31:0] lo_r;        // multiplier -> product low word / dividend -> quotient
   logic [31:0] b_r;         // multiplicand / divisor magnitude
   logic [31:0] result_r;

   logic        a_signed_s;
   logic        b_signed_s;
   logic        a_neg_s;
   logic        b_neg_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic        special_s;
   logic [31:0] special_val_s;
   logic [32:0] mul_sum_s;
   logic [32:0] div_shift_s;
   logic [32:0] div_diff_s;
   logic [63:0] prod_s;
   logic [31:0] fix_val_s;

   // Operand signedness for the op presented in IDLE.
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (bus.funct3)
         3'b001, 3'b100, 3'b110: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
         end
         3'b010: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b0;
         end
         default: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
         end
      endcase
   end

   assign a_neg_s = a_signed_s & bus.rs1_data[31];
   assign b_neg_s = b_signed_s & bus.rs2_data[31];
   // 0x80000000 negates to itself, which is the correct unsigned magnitude.
   assign a_mag_s = cond_neg32(bus.rs1_data, a_neg_s);
   assign b_mag_s = cond_neg32(bus.rs2_data, b_neg_s);

   // Divide special cases that bypass the iterative datapath.
   always_comb begin
      special_s     = 1'b0;
      special_val_s = 32'd0;
      if (bus.funct3[2]) begin
         if (bus.rs2_data == 32'd0) begin
            special_s     = 1'b1;
            special_val_s = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
         end else if (!bus.funct3[0] && (bus.rs1_data == 32'h8000_0000) &&
                      (bus.rs2_data == 32'hFFFF_FFFF)) begin
            special_s     = 1'b1;
            special_val_s = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
         end else begin
            special_s     = 1'b0;
            special_val_s = 32'd0;
         end
      end else begin
         special_s     = 1'b0;
         special_val_s = 32'd0;
      end
   end

   // One iteration of each datapath.
   assign mul_sum_s   = {1'b0, acc_r} + {1'b0, b_r};
   assign div_shift_s = {acc_r, lo_r[31]};
   assign div_diff_s  = div_shift_s - {1'b0, b_r};

   // Sign fix-up and result selection used in FIX.
   assign prod_s = neg_q_r ? (~{acc_r, lo_r} + 64'd1) : {acc_r, lo_r};

   // Final result mux for the FIX state.
   always_comb begin
      fix_val_s = 32'd0;
      if (is_div_r) begin
         if (sel_r[1]) begin
            fix_val_s = cond_neg32(acc_r, neg_r_r);
         end else begin
            fix_val_s = cond_neg32(lo_r, neg_q_r);
         end
      end else begin
         if (sel_r == 2'b00) begin
            fix_val_s = prod_s[31:0];
         end else begin
            fix_val_s = prod_s[63:32];
         end
      end
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 5'd0;
         sel_r    <= 2'd0;
         is_div_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         acc_r    <= 32'd0;
         lo_r     <= 32'd0;
         b_r      <= 32'd0;
         result_r <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start && !bus.flush) begin
                  sel_r    <= bus.funct3[1:0];
                  is_div_r <= bus.funct3[2];
                  neg_q_r  <= a_neg_s ^ b_neg_s;
                  neg_r_r  <= a_neg_s;
                  b_r      <= b_mag_s;
                  lo_r     <= a_mag_s;
                  acc_r    <= 32'd0;
                  cnt_r    <= 5'd0;
                  if (special_s) begin
                     result_r <= special_val_s;
                     state_r  <= ST_DONE;
                  end else begin
                     state_r  <= ST_CALC;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_CALC: begin
               if (bus.flush) begin
                  state_r <= ST_IDLE;
               end else begin
                  if (is_div_r) begin
                     // Non-negative trial difference means the divisor fits.
                     if (!div_diff_s[32]) begin
                        acc_r <= div_diff_s[31:0];
                        lo_r  <= {lo_r[30:0], 1'b1};
                     end else begin
                        acc_r <= div_shift_s[31:0];
                        lo_r  <= {lo_r[30:0], 1'b0};
                     end
                  end else begin
                     // Carry out of the add becomes the new product MSB.
                     if (lo_r[0]) begin
                        {acc_r, lo_r} <= {mul_sum_s, lo_r[31:1]};
                     end else begin
                        {acc_r, lo_r} <= {1'b0, acc_r, lo_r[31:1]};
                     end
                  end
                  cnt_r <= cnt_r + 5'd1;
                  if (cnt_r == 5'd31) begin
                     state_r <= ST_FIX;
                  end else begin
                     state_r <= ST_CALC;
                  end
               end
            end
            ST_FIX: begin
               if (bus.flush) begin
                  state_r <= ST_IDLE;
               end else begin
                  result_r <= fix_val_s;
                  state_r  <= ST_DONE;
               end
            end
            ST_DONE: begin
               // The same instruction is still on start; it must not restart.
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.stall  = ((state_r == ST_IDLE) & bus.start & ~bus.flush) |
                       (state_r == ST_CALC) | (state_r == ST_FIX);
   assign bus.done   = (state_r == ST_DONE);
   assign bus.result = result_r;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   cyc;
   logic        chk_en;
   logic        exp_stall;
   logic        exp_done;
   logic [31:0] exp_result;
   int          done_q[$];

   ex_muldiv_if bus();

   ex_muldiv dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference results straight from the RV32M definitions.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      int sa;
      int sb;
      logic [31:0] r;
      sa = a;
      sb = b;
      r  = 32'd0;
      if (!f3[2]) begin
         ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
         eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
         p  = ea * eb;
         r  = (f3 == 3'd0) ? p[31:0] : p[63:32];
      end else begin
         case (f3)
            3'd4: r = (b == 32'd0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 32'd0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: r = (b == 32'd0) ? a : a % b;
         endcase
      end
      return r;
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return f3[2] && ((b == 32'd0) ||
             (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Per-cycle compare of the DUT against the expected outputs.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
         chk("done", {31'd0, bus.done}, {31'd0, exp_done});
         chk("result", bus.result, exp_result);
         if (bus.done) done_q.push_back(cyc);
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rst = 1'b1;
         bus.start = 1'b0;
         bus.flush = 1'b0;
         bus.funct3 = 3'($urandom);
         bus.rs1_data = $urandom;
         bus.rs2_data = $urandom;
         exp_stall = 1'b0;
         exp_done  = 1'b0;
      end
   endtask

   // Presents one instruction, held on start until it retires, as the
   // pipeline does. flush_at / rst_at < 0 disables that event.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int rst_at);
      int lat;
      logic [31:0] r;
      lat = is_special(f3, a, b) ? 1 : 34;
      r   = model(f3, a, b);
      for (int t = 0; t <= lat; t++) begin
         @(posedge clk); #1;
         bus.start    = 1'b1;
         bus.funct3   = f3;
         bus.rs1_data = a;
         bus.rs2_data = b;
         bus.flush    = (t == flush_at);
         if (t == rst_at) begin
            rst = 1'b0;
            exp_stall  = 1'b1;
            exp_done   = 1'b0;
            exp_result = 32'd0;
            break;
         end else if (t == flush_at && t < lat) begin
            exp_stall = (t != 0);
            exp_done  = 1'b0;
            break;
         end else if (t == lat) begin
            exp_stall  = 1'b0;
            exp_done   = 1'b1;
            exp_result = r;
         end else begin
            exp_stall = 1'b1;
            exp_done  = 1'b0;
         end
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'd0;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      tests = 0;
      fails = 0;
      cyc = 0;
      chk_en = 1'b0;
      rst = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.funct3 = 3'd0;
      bus.rs1_data = 32'd0;
      bus.rs2_data = 32'd0;
      exp_stall = 1'b0;
      exp_done = 1'b0;
      exp_result = 32'd0;

      // Hand-computed values pinning the reference model.
      chk("pin_mul",    model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      chk("pin_mulh",   model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      chk("pin_mulhu",  model(3'd3, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      chk("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
      chk("pin_div",    model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      chk("pin_rem",    model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      chk("pin_divu",   model(3'd5, 32'd100, 32'd7), 32'd14);
      chk("pin_remu",   model(3'd7, 32'd100, 32'd7), 32'd2);
      chk("pin_divz",   model(3'd5, 32'd5, 32'd0), 32'hFFFF_FFFF);
      chk("pin_remz",   model(3'd6, 32'd5, 32'd0), 32'd5);
      chk("pin_divov",  model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("pin_remov",  model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      idle(2);

      // Directed cases.
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1, -1);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1, -1);
      do_op(3'd3, 32'h8000_0000, 32'h8000_0000, -1, -1);
      do_op(3'd2, 32'hFFFF_FFFF, 32'd2, -1, -1);
      idle(1);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1, -1);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1, -1);
      do_op(3'd5, 32'd100, 32'd7, -1, -1);
      do_op(3'd7, 32'd100, 32'd7, -1, -1);
      do_op(3'd5, 32'd5, 32'd0, -1, -1);
      do_op(3'd6, 32'd5, 32'd0, -1, -1);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      // Flush mid-divide, then a new op immediately after.
      do_op(3'd4, 32'd1000, 32'd3, 10, -1);
      do_op(3'd5, 32'd1000, 32'd3, -1, -1);
      // Flush on the counter==31 edge, in FIX, in IDLE, and in DONE.
      do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32, -1);
      do_op(3'd6, 32'hDEAD_BEEF, 32'd77, 33, -1);
      do_op(3'd0, 32'd3, 32'd4, 0, -1);
      idle(1);
      do_op(3'd0, 32'd3, 32'd4, 34, -1);
      idle(1);
      // Reset mid-multiply.
      do_op(3'd0, 32'hFFFF_0001, 32'd12345, -1, 5);
      idle(2);
      // Back-to-back multiplies: done pulses 35 cycles apart.
      done_q.delete();
      do_op(3'd0, 32'd11, 32'd13, -1, -1);
      do_op(3'd0, 32'd17, 32'd19, -1, -1);
      idle(1);
      chk("b2b_count", 32'(done_q.size()), 32'd2);
      if (done_q.size() == 2) begin
         chk("b2b_spacing", 32'(done_q[1] - done_q[0]), 32'd35);
      end else begin
         chk("b2b_spacing", 32'd0, 32'd35);
      end

      // Randomized operations.
      for (int n = 0; n < 60; n++) begin
         logic [2:0] f3;
         int fa;
         f3 = 3'($urandom_range(0, 7));
         fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 34)) : -1;
         do_op(f3, pick(), pick(), fa, -1);
         idle($urandom_range(0, 2));
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
